scratchpad_seq: RTL and testbench
=================================

Name: scratchpad_seq

Overview:
- Parametrised scratchpad with N_BG bank groups. Each bank group is a single-port DEPTH x DATA_W memory.
- Contains a CFG_DEPTH-entry configuration buffer and a sequencer. The sequencer steps through the stored entries, each for a programmable number of cycles, optionally looping.
- Each active entry routes every bank group to either the shared external port or that group's dedicated switch port.
- Sits between the external load/store bus and the array switch network.

Parameters:
- N_BG, 4, number of bank groups / switch ports
- DATA_W, 32, data word width
- AW, 10, address width; DEPTH = 2**AW words per bank group
- CFG_DEPTH, 8, configuration buffer entries
- CNT_W, 8, width of per-step hold field
- Derived: CFG_W = 2*N_BG + CNT_W; PW = clog2(CFG_DEPTH)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cfg_we  in  1  append cfg_wdata to configuration buffer
- cfg_wdata  in  CFG_W  entry = {en[N_BG-1:0], sel[N_BG-1:0], hold[CNT_W-1:0]}
- cfg_clr  in  1  empty configuration buffer
- cfg_full  out  1  buffer holds CFG_DEPTH entries
- start  in  1  begin sequence
- loop  in  1  sampled with start; 1 = wrap to step 0 after last step
- stop  in  1  abort running sequence
- busy  out  1  sequencer in RUN
- done  out  1  one-cycle pulse at normal completion
- step_idx  out  PW  index of active entry
- ex_we, ex_re  in  1 each  external write/read strobes
- ex_addr  in  AW  external address
- ex_wdata  in  DATA_W  external write data
- ex_rdata  out  DATA_W  external read data
- ex_rvalid  out  1  ex_rdata valid
- sw_we, sw_re  in  N_BG each  per-switch-port strobes
- sw_addr  in  N_BG*AW  packed; port b at [b*AW +: AW]
- sw_wdata  in  N_BG*DATA_W  packed write data
- sw_rdata  out  N_BG*DATA_W  packed read data
- sw_rvalid  out  N_BG  per-port read valid

Behaviour:
- Reset values:
  - state IDLE; cfg count 0; active entry all-zero (all groups disabled)
  - busy=0, done=0, cfg_full=0, step_idx=0
  - ex_rvalid=0, ex_rdata=0; sw_rvalid=0, sw_rdata=0
  - memory contents undefined, not cleared
- Config load, IDLE only:
  - cfg_we writes entry at index cnt; cnt increments.
  - cfg_we when cnt==CFG_DEPTH is dropped; cnt saturates and cfg_full stays 1.
  - cfg_clr sets cnt=0 and has priority over cfg_we in the same cycle.
  - cfg_we and cfg_clr during RUN are ignored.
- FSM states: IDLE, RUN.
  - IDLE->RUN on start with cnt>0. start with cnt==0 is ignored.
  - At the start cycle: entry 0 loads into the active register, loop is latched, hold counter = entry0.hold. Entry 0 is active from the next cycle.
  - Each step is active for hold+1 cycles (hold=0 means 1 cycle).
  - When the counter reaches 0 on step cnt-1:
    - if latched loop=1: load entry 0, step_idx=0, no gap cycle;
    - otherwise: RUN->IDLE, done=1 for one cycle, active entry cleared.
  - Otherwise advance to step_idx+1 with no gap cycle.
  - stop in RUN: IDLE next cycle, active entry cleared, done stays 0. stop has priority over step advance. start during RUN is ignored.
- Routing for group b, from the active entry:
  - en[b]=0: group ignores all accesses and its rvalid stays 0.
  - en[b]=1, sel[b]=1: group driven by switch port b.
  - en[b]=1, sel[b]=0: group driven by the external port. External writes broadcast to every such group.
- Access timing:
  - Write commits at the clock edge.
  - Read latency is 1 cycle: rdata registered, rvalid is a one-cycle pulse.
  - we and re to the same address in the same cycle: read returns the old data.
  - rdata holds its last value when rvalid=0.
- ex_rdata source:
  - Lowest-indexed group with en=1, sel=0 at the time ex_re was issued.
  - No such group: ex_re is dropped and ex_rvalid stays 0.
- A read issued in the last cycle of a step still returns its data and rvalid in the next cycle, even if the group becomes disabled.
- Reset mid-RUN: immediate return to the reset values. cfg count is cleared, so the buffer must be reloaded.

Test Plan:
1. Reset, load 2 entries: e0 {en=0xF, sel=0x0, hold=0}, e1 {en=0xF, sel=0xF, hold=2}; start, loop=0.
   -> busy for 4 cycles; step_idx 0,1,1,1; done pulses once; busy=0 after.
2. In e0: ex_we addr 5 data 0xA5A5A5A5, then in e1: sw_re on all ports, addr 5.
   -> all 4 sw_rvalid high 1 cycle later, each sw_rdata = 0xA5A5A5A5.
3. Load CFG_DEPTH+1 entries.
   -> cfg_full=1 after the 8th; 9th dropped. start runs exactly 8 steps (hold=0 each), then done.
4. Load 3 entries with hold=1, start with loop=1.
   -> step_idx sequence 0,0,1,1,2,2,0,0,... with no gap. stop asserted mid-step -> busy=0 next cycle, done never asserts.
5. Entry {en=0x6, sel=0x4}; ex_re addr 3.
   -> data from BG1 only. sw_we on port 0 is ignored: BG0 is unchanged when read back later.
6. Same-cycle sw_we and sw_re on port 2, addr 7, new data 0x1234, old data 0x55.
   -> sw_rdata[2]=0x55; the following read returns 0x1234. rst asserted mid-RUN -> all outputs reach reset values next cycle.

Source files
------------

// File: rtl/scratchpad_seq.sv
// scratchpad_seq: banked scratchpad with a programmable routing sequencer.
//
// N_BG single-port DEPTH x DATA_W bank groups sit between the external
// load/store port and N_BG dedicated switch ports. A small configuration
// buffer holds up to CFG_DEPTH routing entries {en, sel, hold}. Once started,
// the sequencer makes each entry active for hold+1 cycles, in order, and can
// wrap to entry 0. The active entry decides, per bank group, whether the group
// is disabled, owned by the external port, or owned by its switch port.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cfg_we/cfg_wdata/cfg_clr configuration append / clear (IDLE only)
//   cfg_full                 configuration buffer holds CFG_DEPTH entries
//   start/loop/stop          sequencer control
//   busy/done/step_idx       sequencer status
//   ex_*                     external port (writes broadcast to ext-owned groups)
//   sw_*                     packed per-group switch ports
module scratchpad_seq #(
  parameter int N_BG      = 4,
  parameter int DATA_W    = 32,
  parameter int AW        = 10,
  parameter int CFG_DEPTH = 8,
  parameter int CNT_W     = 8,
  localparam int CFG_W    = 2 * N_BG + CNT_W,
  localparam int PW       = (CFG_DEPTH > 1) ? $clog2(CFG_DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic [CFG_W-1:0]         cfg_wdata,
  input  logic                     cfg_clr,
  output logic                     cfg_full,
  input  logic                     start,
  input  logic                     loop,
  input  logic                     stop,
  output logic                     busy,
  output logic                     done,
  output logic [PW-1:0]            step_idx,
  input  logic                     ex_we,
  input  logic                     ex_re,
  input  logic [AW-1:0]            ex_addr,
  input  logic [DATA_W-1:0]        ex_wdata,
  output logic [DATA_W-1:0]        ex_rdata,
  output logic                     ex_rvalid,
  input  logic [N_BG-1:0]          sw_we,
  input  logic [N_BG-1:0]          sw_re,
  input  logic [N_BG*AW-1:0]       sw_addr,
  input  logic [N_BG*DATA_W-1:0]   sw_wdata,
  output logic [N_BG*DATA_W-1:0]   sw_rdata,
  output logic [N_BG-1:0]          sw_rvalid
);

  localparam int DEPTH = 1 << AW;
  localparam int BGW   = (N_BG > 1) ? $clog2(N_BG) : 1;
  localparam logic [PW:0] CNT_MAX = (PW+1)'(CFG_DEPTH);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  // Entry field helpers: entry = {en, sel, hold}
  function automatic logic [N_BG-1:0] ent_en(input logic [CFG_W-1:0] e);
    return e[CFG_W-1 -: N_BG];
  endfunction

  function automatic logic [N_BG-1:0] ent_sel(input logic [CFG_W-1:0] e);
    return e[CNT_W +: N_BG];
  endfunction

  function automatic logic [CNT_W-1:0] ent_hold(input logic [CFG_W-1:0] e);
    return e[CNT_W-1:0];
  endfunction

  state_t              state_q, state_d;
  logic [PW:0]         cnt_q, cnt_d;
  logic [CFG_W-1:0]    cfg_mem_q [CFG_DEPTH];
  logic [CFG_W-1:0]    cfg_mem_d [CFG_DEPTH];
  logic                cfg_full_q, cfg_full_d;
  logic [PW-1:0]       step_q, step_d;
  logic [CNT_W-1:0]    hold_q, hold_d;
  logic                loop_q, loop_d;
  logic [N_BG-1:0]     act_en_q, act_en_d;
  logic [N_BG-1:0]     act_sel_q, act_sel_d;
  logic                done_q, done_d;

  logic                load_s;
  logic [CFG_W-1:0]    load_ent_s;
  logic                last_step_s;

  logic [DATA_W-1:0]   bank_mem [N_BG][DEPTH];

  logic [N_BG-1:0]     grp_we;
  logic [N_BG-1:0]     grp_re;
  logic [AW-1:0]       grp_addr  [N_BG];
  logic [DATA_W-1:0]   grp_wdata [N_BG];

  logic                ex_hit;
  logic [BGW-1:0]      ex_grp;

  logic                ex_rvalid_q, ex_rvalid_d;
  logic [DATA_W-1:0]   ex_rdata_q, ex_rdata_d;
  logic [N_BG-1:0]     sw_rvalid_q, sw_rvalid_d;
  logic [DATA_W-1:0]   sw_rdata_q [N_BG];
  logic [DATA_W-1:0]   sw_rdata_d [N_BG];

  // The last step is the one at index cnt-1 (cnt is never 0 while running).
  assign last_step_s = ({1'b0, step_q} == (cnt_q - 1'b1));

  // Sequencer and configuration-buffer next state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cfg_mem_d  = cfg_mem_q;
    step_d     = step_q;
    hold_d     = hold_q;
    loop_d     = loop_q;
    act_en_d   = act_en_q;
    act_sel_d  = act_sel_q;
    done_d     = 1'b0;
    load_s     = 1'b0;
    load_ent_s = cfg_mem_q[0];
    case (state_q)
      S_IDLE: begin
        // start wins over a same-cycle configuration edit
        if (start && (cnt_q != '0)) begin
          state_d    = S_RUN;
          loop_d     = loop;
          step_d     = '0;
          load_s     = 1'b1;
          load_ent_s = cfg_mem_q[0];
        end else if (cfg_clr) begin
          cnt_d = '0;
        end else if (cfg_we && (cnt_q != CNT_MAX)) begin
          cfg_mem_d[cnt_q[PW-1:0]] = cfg_wdata;
          cnt_d = cnt_q + 1'b1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d   = S_IDLE;
          step_d    = '0;
          hold_d    = '0;
          act_en_d  = '0;
          act_sel_d = '0;
        end else if (hold_q != '0) begin
          hold_d = hold_q - 1'b1;
        end else if (last_step_s) begin
          if (loop_q) begin
            step_d     = '0;
            load_s     = 1'b1;
            load_ent_s = cfg_mem_q[0];
          end else begin
            state_d   = S_IDLE;
            done_d    = 1'b1;
            step_d    = '0;
            act_en_d  = '0;
            act_sel_d = '0;
          end
        end else begin
          step_d     = step_q + 1'b1;
          load_s     = 1'b1;
          load_ent_s = cfg_mem_q[step_q + 1'b1];
        end
      end
      default: begin
        state_d   = S_IDLE;
        step_d    = '0;
        act_en_d  = '0;
        act_sel_d = '0;
      end
    endcase
    if (load_s) begin
      act_en_d  = ent_en(load_ent_s);
      act_sel_d = ent_sel(load_ent_s);
      hold_d    = ent_hold(load_ent_s);
    end else begin
      hold_d = hold_d;
    end
    cfg_full_d = (cnt_d == CNT_MAX);
  end

  // Sequencer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cfg_full_q <= 1'b0;
      step_q     <= '0;
      hold_q     <= '0;
      loop_q     <= 1'b0;
      act_en_q   <= '0;
      act_sel_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cfg_full_q <= cfg_full_d;
      step_q     <= step_d;
      hold_q     <= hold_d;
      loop_q     <= loop_d;
      act_en_q   <= act_en_d;
      act_sel_q  <= act_sel_d;
      done_q     <= done_d;
    end
  end

  // Configuration storage; contents are meaningless beyond cnt, so no reset.
  always_ff @(posedge clk) begin
    cfg_mem_q <= cfg_mem_d;
  end

  // Per-group port mux driven by the active entry.
  always_comb begin
    for (int b = 0; b < N_BG; b++) begin
      grp_we[b]    = 1'b0;
      grp_re[b]    = 1'b0;
      grp_addr[b]  = '0;
      grp_wdata[b] = '0;
      if (act_en_q[b]) begin
        if (act_sel_q[b]) begin
          grp_we[b]    = sw_we[b];
          grp_re[b]    = sw_re[b];
          grp_addr[b]  = sw_addr[b*AW +: AW];
          grp_wdata[b] = sw_wdata[b*DATA_W +: DATA_W];
        end else begin
          grp_we[b]    = ex_we;
          grp_re[b]    = ex_re;
          grp_addr[b]  = ex_addr;
          grp_wdata[b] = ex_wdata;
        end
      end else begin
        grp_we[b] = 1'b0;
      end
    end
  end

  // External reads come from the lowest-indexed externally owned group.
  always_comb begin
    ex_hit = 1'b0;
    ex_grp = '0;
    for (int b = N_BG - 1; b >= 0; b--) begin
      if (act_en_q[b] && !act_sel_q[b]) begin
        ex_hit = 1'b1;
        ex_grp = BGW'(b);
      end else begin
        ex_hit = ex_hit;
      end
    end
  end

  // Bank storage; no reset so the arrays stay plain RAM.
  always_ff @(posedge clk) begin
    for (int b = 0; b < N_BG; b++) begin
      if (!rst && grp_we[b]) begin
        bank_mem[b][grp_addr[b]] <= grp_wdata[b];
      end
    end
  end

  // Read data capture; rdata holds its value when no read is issued.
  always_comb begin
    ex_rvalid_d = ex_re && ex_hit;
    if (ex_rvalid_d) begin
      ex_rdata_d = bank_mem[ex_grp][ex_addr];
    end else begin
      ex_rdata_d = ex_rdata_q;
    end
    for (int b = 0; b < N_BG; b++) begin
      sw_rvalid_d[b] = grp_re[b] && act_sel_q[b];
      if (sw_rvalid_d[b]) begin
        sw_rdata_d[b] = bank_mem[b][grp_addr[b]];
      end else begin
        sw_rdata_d[b] = sw_rdata_q[b];
      end
    end
  end

  // Read-port output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_rvalid_q <= 1'b0;
      ex_rdata_q  <= '0;
      sw_rvalid_q <= '0;
      for (int b = 0; b < N_BG; b++) begin
        sw_rdata_q[b] <= '0;
      end
    end else begin
      ex_rvalid_q <= ex_rvalid_d;
      ex_rdata_q  <= ex_rdata_d;
      sw_rvalid_q <= sw_rvalid_d;
      for (int b = 0; b < N_BG; b++) begin
        sw_rdata_q[b] <= sw_rdata_d[b];
      end
    end
  end

  // Pack switch read data onto the flat output bus.
  always_comb begin
    for (int b = 0; b < N_BG; b++) begin
      sw_rdata[b*DATA_W +: DATA_W] = sw_rdata_q[b];
    end
  end

  assign cfg_full  = cfg_full_q;
  assign busy      = (state_q == S_RUN);
  assign done      = done_q;
  assign step_idx  = step_q;
  assign ex_rdata  = ex_rdata_q;
  assign ex_rvalid = ex_rvalid_q;
  assign sw_rvalid = sw_rvalid_q;

endmodule

// File: tb/tb_scratchpad_seq.sv
// Directed bench for scratchpad_seq with a schedule-based reference model.
module tb_scratchpad_seq;

  localparam int N_BG = 4;
  localparam int DATA_W = 32;
  localparam int AW = 10;
  localparam int CFG_DEPTH = 8;
  localparam int CNT_W = 8;
  localparam int CFG_W = 2 * N_BG + CNT_W;
  localparam int PW = 3;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_we = 1'b0;
  logic [CFG_W-1:0] cfg_wdata = '0;
  logic cfg_clr = 1'b0;
  logic cfg_full;
  logic start = 1'b0;
  logic loop = 1'b0;
  logic stop = 1'b0;
  logic busy;
  logic done;
  logic [PW-1:0] step_idx;
  logic ex_we = 1'b0;
  logic ex_re = 1'b0;
  logic [AW-1:0] ex_addr = '0;
  logic [DATA_W-1:0] ex_wdata = '0;
  logic [DATA_W-1:0] ex_rdata;
  logic ex_rvalid;
  logic [N_BG-1:0] sw_we = '0;
  logic [N_BG-1:0] sw_re = '0;
  logic [N_BG*AW-1:0] sw_addr = '0;
  logic [N_BG*DATA_W-1:0] sw_wdata = '0;
  logic [N_BG*DATA_W-1:0] sw_rdata;
  logic [N_BG-1:0] sw_rvalid;

  scratchpad_seq #(.N_BG(N_BG), .DATA_W(DATA_W), .AW(AW), .CFG_DEPTH(CFG_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_wdata(cfg_wdata), .cfg_clr(cfg_clr),
    .cfg_full(cfg_full), .start(start), .loop(loop), .stop(stop), .busy(busy),
    .done(done), .step_idx(step_idx), .ex_we(ex_we), .ex_re(ex_re), .ex_addr(ex_addr),
    .ex_wdata(ex_wdata), .ex_rdata(ex_rdata), .ex_rvalid(ex_rvalid), .sw_we(sw_we),
    .sw_re(sw_re), .sw_addr(sw_addr), .sw_wdata(sw_wdata), .sw_rdata(sw_rdata),
    .sw_rvalid(sw_rvalid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [CFG_W-1:0] mk(logic [N_BG-1:0] en, logic [N_BG-1:0] sel, logic [CNT_W-1:0] hold);
    return {en, sel, hold};
  endfunction

  // ---------------- reference model ----------------
  // The sequencer is modelled as a queue of step indices, one per cycle.
  logic [CFG_W-1:0] cfg_m [$];
  int rem [$];
  bit m_started = 1'b0;
  bit m_run, m_loop, m_done;
  int m_step;
  logic [N_BG-1:0] m_en, m_sel;
  logic [DATA_W-1:0] mem_m [N_BG][DEPTH];
  bit known [N_BG][DEPTH];
  bit m_ex_rv, m_ex_known;
  logic [DATA_W-1:0] m_ex_rd;
  logic [N_BG-1:0] m_sw_rv;
  logic [DATA_W-1:0] m_sw_rd [N_BG];
  bit m_sw_known [N_BG];

  task automatic fill();
    logic [CFG_W-1:0] e;
    rem.delete();
    foreach (cfg_m[i]) begin
      e = cfg_m[i];
      repeat (int'(e[CNT_W-1:0]) + 1) rem.push_back(i);
    end
  endtask

  always @(posedge clk) begin
    int src;
    bit was_run;
    logic [CFG_W-1:0] e;
    logic [AW-1:0] a;
    if (rst) begin
      cfg_m.delete(); rem.delete();
      m_run = 0; m_loop = 0; m_done = 0; m_step = 0; m_en = '0; m_sel = '0;
      m_ex_rv = 0; m_ex_rd = '0; m_ex_known = 1; m_sw_rv = '0;
      for (int b = 0; b < N_BG; b++) begin m_sw_rd[b] = '0; m_sw_known[b] = 1; end
      m_started = 1;
    end else if (m_started) begin
      src = -1;
      for (int b = N_BG - 1; b >= 0; b--) if (m_en[b] && !m_sel[b]) src = b;
      m_ex_rv = 0;
      if (ex_re && src >= 0) begin
        m_ex_rv = 1; m_ex_rd = mem_m[src][ex_addr]; m_ex_known = known[src][ex_addr];
      end
      for (int b = 0; b < N_BG; b++) begin
        a = sw_addr[b*AW +: AW];
        m_sw_rv[b] = m_en[b] && m_sel[b] && sw_re[b];
        if (m_sw_rv[b]) begin m_sw_rd[b] = mem_m[b][a]; m_sw_known[b] = known[b][a]; end
      end
      for (int b = 0; b < N_BG; b++) begin
        a = sw_addr[b*AW +: AW];
        if (m_en[b] && m_sel[b] && sw_we[b]) begin
          mem_m[b][a] = sw_wdata[b*DATA_W +: DATA_W]; known[b][a] = 1;
        end
        if (m_en[b] && !m_sel[b] && ex_we) begin
          mem_m[b][ex_addr] = ex_wdata; known[b][ex_addr] = 1;
        end
      end
      was_run = m_run;
      m_done = 0;
      if (was_run) begin
        if (stop) begin m_run = 0; rem.delete(); end
        else if (rem.size() == 0) begin
          if (m_loop) begin fill(); m_step = rem.pop_front(); end
          else begin m_run = 0; m_done = 1; end
        end else m_step = rem.pop_front();
      end else if (start && cfg_m.size() > 0) begin
        m_run = 1; m_loop = loop; fill(); m_step = rem.pop_front();
      end else if (cfg_clr) cfg_m.delete();
      else if (cfg_we && cfg_m.size() < CFG_DEPTH) cfg_m.push_back(cfg_wdata);
      if (!m_run) begin m_step = 0; m_en = '0; m_sel = '0; end
      else begin e = cfg_m[m_step]; m_en = e[CFG_W-1 -: N_BG]; m_sel = e[CNT_W +: N_BG]; end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    if (m_started) begin
      chk("cmp_busy", busy, m_run);
      chk("cmp_done", done, m_done);
      chk("cmp_step_idx", step_idx, m_step);
      chk("cmp_cfg_full", cfg_full, cfg_m.size() == CFG_DEPTH);
      chk("cmp_ex_rvalid", ex_rvalid, m_ex_rv);
      chk("cmp_sw_rvalid", sw_rvalid, m_sw_rv);
      if (m_ex_known) chk("cmp_ex_rdata", ex_rdata, m_ex_rd);
      for (int b = 0; b < N_BG; b++)
        if (m_sw_known[b]) chk("cmp_sw_rdata", sw_rdata[b*DATA_W +: DATA_W], m_sw_rd[b]);
    end
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic load(logic [CFG_W-1:0] e);
    cfg_we = 1'b1; cfg_wdata = e;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic clr();
    cfg_clr = 1'b1;
    @(negedge clk);
    cfg_clr = 1'b0;
  endtask

  task automatic go(logic lp);
    start = 1'b1; loop = lp;
    @(negedge clk);
    start = 1'b0; loop = 1'b0;
  endtask

  task automatic sw_all_addr(logic [AW-1:0] a);
    for (int b = 0; b < N_BG; b++) sw_addr[b*AW +: AW] = a;
  endtask

  task automatic wait_idle(int maxc);
    int n = 0;
    while (busy && n < maxc) begin @(negedge clk); n++; end
    chk("idle_timeout", busy, 1'b0);
  endtask

  initial begin
    int n;
    int exp4 [10] = '{0, 0, 1, 1, 2, 2, 0, 0, 1, 1};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_cfg_full", cfg_full, 1'b0);
    chk("rst_step", step_idx, 3'd0);
    chk("rst_rvalid", {ex_rvalid, sw_rvalid}, 5'd0);

    // Plan 1 & 2: two-step run with external write then switch read
    load(mk(4'hF, 4'h0, 8'd0));
    load(mk(4'hF, 4'hF, 8'd2));
    go(1'b0);
    chk("t1_busy_c0", busy, 1'b1);
    chk("t1_step_c0", step_idx, 3'd0);
    ex_we = 1'b1; ex_addr = 10'd5; ex_wdata = 32'hA5A5A5A5;
    @(negedge clk);
    ex_we = 1'b0;
    chk("t1_step_c1", step_idx, 3'd1);
    sw_re = 4'hF; sw_all_addr(10'd5);
    @(negedge clk);
    sw_re = 4'h0;
    chk("t2_sw_rvalid", sw_rvalid, 4'hF);
    for (int b = 0; b < N_BG; b++) chk("t2_sw_rdata", sw_rdata[b*DATA_W +: DATA_W], 32'hA5A5A5A5);
    chk("t1_step_c2", step_idx, 3'd1);
    @(negedge clk);
    chk("t1_step_c3", step_idx, 3'd1);
    chk("t2_rvalid_pulse", sw_rvalid, 4'h0);
    chk("t2_rdata_hold", sw_rdata[DATA_W-1:0], 32'hA5A5A5A5);
    @(negedge clk);
    chk("t1_busy_end", busy, 1'b0);
    chk("t1_done", done, 1'b1);
    @(negedge clk);
    chk("t1_done_pulse", done, 1'b0);

    // Plan 3: overfill the buffer, then run eight single-cycle steps
    clr();
    for (int i = 0; i < CFG_DEPTH + 1; i++) begin
      load(mk(4'h0, 4'(i), 8'd0));
      if (i == CFG_DEPTH - 2) chk("t3_not_full", cfg_full, 1'b0);
      if (i >= CFG_DEPTH - 1) chk("t3_full", cfg_full, 1'b1);
    end
    go(1'b0);
    n = 0;
    while (busy && n < 20) begin
      chk("t3_step", step_idx, n);
      @(negedge clk); n++;
    end
    chk("t3_steps", n, 8);
    chk("t3_done", done, 1'b1);

    // start with an empty buffer is ignored
    clr();
    go(1'b0);
    chk("t3_empty_start", busy, 1'b0);

    // Plan 4: looping run with hold=1, then stop
    for (int i = 0; i < 3; i++) load(mk(4'h0, 4'h0, 8'd1));
    go(1'b1);
    for (int k = 0; k < 10; k++) begin
      chk("t4_step", step_idx, exp4[k]);
      chk("t4_busy", busy, 1'b1);
      if (k < 9) @(negedge clk);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("t4_stop_busy", busy, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk("t4_no_done", done, 1'b0);
      @(negedge clk);
    end

    // Plan 5: seed addr 3 of each group, then mixed routing
    clr();
    load(mk(4'hF, 4'hF, 8'd30));
    go(1'b0);
    sw_we = 4'hF; sw_all_addr(10'd3);
    for (int b = 0; b < N_BG; b++) sw_wdata[b*DATA_W +: DATA_W] = 32'h100 + 32'(b);
    @(negedge clk);
    sw_we = 4'h0;
    wait_idle(40);
    clr();
    load(mk(4'h6, 4'h4, 8'd30));
    go(1'b0);
    ex_re = 1'b1; ex_addr = 10'd3;
    sw_we = 4'h1; sw_wdata[DATA_W-1:0] = 32'hDEAD;
    sw_re = 4'h2;
    @(negedge clk);
    ex_re = 1'b0; sw_we = 4'h0; sw_re = 4'h0;
    chk("t5_ex_rvalid", ex_rvalid, 1'b1);
    chk("t5_ex_rdata", ex_rdata, 32'h101);
    chk("t5_sw_rvalid", sw_rvalid, 4'h0);
    wait_idle(40);
    clr();
    load(mk(4'hF, 4'hF, 8'd30));
    go(1'b0);
    sw_re = 4'h1;
    @(negedge clk);
    sw_re = 4'h0;
    chk("t5_bg0_unchanged", sw_rdata[DATA_W-1:0], 32'h100);

    // Plan 6: same-cycle read/write on port 2, then reset mid-run
    sw_all_addr(10'd7);
    sw_we = 4'h4; sw_wdata[2*DATA_W +: DATA_W] = 32'h55;
    @(negedge clk);
    sw_wdata[2*DATA_W +: DATA_W] = 32'h1234; sw_re = 4'h4;
    @(negedge clk);
    sw_we = 4'h0; sw_re = 4'h0;
    chk("t6_old_data", sw_rdata[2*DATA_W +: DATA_W], 32'h55);
    sw_re = 4'h4;
    @(negedge clk);
    sw_re = 4'h0;
    chk("t6_new_data", sw_rdata[2*DATA_W +: DATA_W], 32'h1234);
    chk("t6_still_busy", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_done", done, 1'b0);
    chk("t6_rst_step", step_idx, 3'd0);
    chk("t6_rst_full", cfg_full, 1'b0);
    chk("t6_rst_rvalid", {ex_rvalid, sw_rvalid}, 5'd0);
    chk("t6_rst_ex_rdata", ex_rdata, 32'h0);
    chk("t6_rst_sw_rdata", sw_rdata, 128'h0);
    go(1'b0);
    chk("t6_cfg_cleared", busy, 1'b0);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
